instr_encoder: RTL and testbench

- Inverse of the instruction decoder: accepts decoded RISC-V RV32I fields and assembles the 32-bit instruction word.
- Accepted fields pass through a valid/ready input port and are buffered in a small FIFO.
- Each entry is emitted with a sequential instruction-memory write address.
- Used as a program loader: it feeds imem writes from a bench or a boot sequencer.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/instr_fifo.sv | 66 ++++++
 rtl/instr_encoder.sv | 100 ++++++++++
 tb/tb_instr_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_pkg                                                                  |
// | RV32I format codes, opcodes and field positions shared by encoder/decoder. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNC3_LSB  = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNC7_LSB  = 25;

  // Branch and jump offsets are halfword-aligned; an odd offset cannot be encoded.
  function automatic logic fmt_is_legal(input logic [2:0] fmt, input logic imm0);
    logic ok;
    ok = (fmt <= FMT_J);
    if ((fmt == FMT_B || fmt == FMT_J) && imm0) ok = 1'b0;
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// +----------------------------------------------------------------------------+
// | instr_fifo                                                                 |
// | Parameterised synchronous FIFO with registered head and exact occupancy.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// +----------------------------------------------------------------------------+
// | instr_encoder                                                              |
// | Assembles RV32I words from decoded fields and queues them as imem writes.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    fmt,
  input  logic [6:0]                    opcode,
  input  logic [2:0]                    func3,
  input  logic [6:0]                    func7,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  input  logic [4:0]                    rd,
  input  logic [20:0]                   imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_addr,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam logic [31:0] c_addr_step = 32'd4;

  logic        r_rdy;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] w_instr;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;

  always_comb begin
    w_instr = '0;
    case (fmt)
      FMT_R:   w_instr = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I:   w_instr = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S:   w_instr = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B:   w_instr = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U:   w_instr = {imm[19:0], rd, opcode};
      FMT_J:   w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_instr = '0;
    endcase
  end

  assign w_legal  = fmt_is_legal(fmt, imm[0]);
  // Illegal bundles still complete the handshake; they are only kept out of the FIFO.
  assign in_ready = r_rdy && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = out_valid && out_ready;

  assign out_valid = !w_empty;
  assign out_addr  = r_addr;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy  <= 1'b0;
      r_err  <= 1'b0;
      r_addr <= BASE_ADDR;
    end else begin
      r_rdy <= 1'b1;
      r_err <= w_accept && !w_legal;
      if (w_pop) r_addr <= r_addr + c_addr_step;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_instr),
    .pop       (w_pop),
    .head      (out_instr),
    .full      (w_full),
    .empty     (w_empty),
    .count     (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// +----------------------------------------------------------------------------+
// | tb_instr_encoder                                                           |
// | Directed scoreboard bench for instr_encoder.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_encoder;

  localparam int          c_depth = 4;
  localparam logic [31:0] c_base  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  rd = '0;
  logic [20:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [2:0]  count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] exp_addr = c_base;
  logic        exp_err = 1'b0;
  logic        rdy_m = 1'b0;
  logic [31:0] cur_exp = '0;
  logic        cur_legal = 1'b1;
  bit          acc;

  instr_encoder #(
    .FIFO_DEPTH (c_depth),
    .BASE_ADDR  (c_base)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .func3     (func3),
    .func7     (func7),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: compare against the model, then advance the model across the next edge.
  task automatic tick(output bit accepted);
    bit   push, pop;
    logic in_rdy_m;
    #1;
    in_rdy_m = rdy_m && (q.size() < c_depth);
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(in_rdy_m));
    chk("err", 32'(err), 32'(exp_err));
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0]);
      chk("out_addr", out_addr, exp_addr);
    end
    push    = in_valid && in_rdy_m;
    pop     = (q.size() != 0) && out_ready;
    exp_err = push && !cur_legal;
    if (pop) begin
      void'(q.pop_front());
      exp_addr = exp_addr + 32'd4;
    end
    if (push && cur_legal) q.push_back(cur_exp);
    rdy_m    = 1'b1;
    accepted = push;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] d, input logic [20:0] im,
                            input logic [31:0] ex, input logic lg);
    fmt = f; opcode = op; func3 = f3; func7 = f7;
    rs1 = s1; rs2 = s2; rd = d; imm = im;
    cur_exp = ex; cur_legal = lg;
  endtask

  task automatic wait_accept(input string tag);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 20) begin
      tick(a);
      n++;
    end
    in_valid  = 1'b0;
    cur_legal = 1'b1;
    checks++;
    assert (a) else begin
      errors++;
      $error("FAIL %s_accept observed=0 expected=1", tag);
    end
  endtask

  task automatic send(input string tag, input logic [2:0] f, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d, input logic [20:0] im,
                      input logic [31:0] ex, input logic lg);
    set_fields(f, op, f3, f7, s1, s2, d, im, ex, lg);
    in_valid = 1'b1;
    wait_accept(tag);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without a clock.
  task automatic apply_reset();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, c_base);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    q.delete();
    exp_addr = c_base;
    exp_err  = 1'b0;
    rdy_m    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] addi_enc(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    apply_reset();
    idle(1);
    out_ready = 1'b1;

    send("r_add", 3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd1, 21'd0, 32'h0020_80B3, 1'b1);
    idle(2);

    send("beq", 3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 21'd2048, 32'h0020_80E3, 1'b1);
    send("jal", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 21'd524288, 32'h0008_00EF, 1'b1);
    send("sw",  3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 21'd8, 32'h0020_A423, 1'b1);
    idle(3);

    send("addi_neg", 3'd1, 7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd3, 21'h1F_F800, 32'h8002_0193, 1'b1);
    send("lui", 3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 21'h1_2345, 32'h1234_52B7, 1'b1);
    idle(3);

    send("ill_fmt7", 3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 21'd4, 32'd0, 1'b0);
    idle(1);
    send("ill_b_odd", 3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 21'd3, 32'd0, 1'b0);
    idle(2);

    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send("bp_fill", 3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'(k), 21'(k), addi_enc(k), 1'b1);
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 21'd5, addi_enc(5), 1'b1);
    in_valid = 1'b1;
    repeat (3) tick(acc);
    out_ready = 1'b1;
    wait_accept("bp_fifth");
    idle(6);

    apply_reset();
    out_ready = 1'b1;
    send("pre_a", 3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 21'd0, 32'h0041_82B3, 1'b1);
    send("pre_b", 3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 21'd0, 32'h4041_82B3, 1'b1);
    idle(2);
    out_ready = 1'b0;
    send("hold_a", 3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd6, 21'd6, addi_enc(6), 1'b1);
    send("hold_b", 3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 21'd7, addi_enc(7), 1'b1);
    chk("mid_count", 32'(count), 32'd2);
    chk("mid_addr", out_addr, 32'h0000_0008);
    apply_reset();
    out_ready = 1'b1;
    send("post_rst", 3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd1, 21'd0, 32'h0020_80B3, 1'b1);
    chk("post_rst_addr", out_addr, c_base);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
